// File: rtl/scoreboard_mwb.sv
// Per-warp register scoreboard with multi-port writeback, pending-write counters and
// round-robin issue from one staging slot per warp into a registered output stage.
module scoreboard_mwb #(
    parameter int unsigned NUM_WARPS = 4,
    parameter int unsigned NUM_REGS  = 64,
    parameter int unsigned NUM_WB    = 2,
    parameter int unsigned CNT_W     = 2,
    parameter int unsigned WAW_MODE  = 0,
    parameter int unsigned DATAW     = 64,
    parameter int unsigned PERF_W    = 32,
    localparam int unsigned RB = $clog2(NUM_REGS),
    localparam int unsigned WW = (NUM_WARPS > 1) ? $clog2(NUM_WARPS) : 1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NUM_WARPS-1:0]     in_valid,
    output logic [NUM_WARPS-1:0]     in_ready,
    input  logic [NUM_WARPS*RB-1:0]  in_rd,
    input  logic [NUM_WARPS*RB-1:0]  in_rs1,
    input  logic [NUM_WARPS*RB-1:0]  in_rs2,
    input  logic [NUM_WARPS*RB-1:0]  in_rs3,
    input  logic [NUM_WARPS*3-1:0]   in_used_rs,
    input  logic [NUM_WARPS-1:0]     in_wb,
    input  logic [NUM_WARPS-1:0]     in_rl,
    input  logic [NUM_WARPS*DATAW-1:0] in_data,
    input  logic [NUM_WARPS-1:0]     st_pending,
    input  logic [NUM_WB-1:0]        wb_valid,
    input  logic [NUM_WB*WW-1:0]     wb_wid,
    input  logic [NUM_WB*RB-1:0]     wb_rd,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [WW-1:0]            out_wid,
    output logic [RB-1:0]            out_rd,
    output logic [RB-1:0]            out_rs1,
    output logic [RB-1:0]            out_rs2,
    output logic [RB-1:0]            out_rs3,
    output logic [2:0]               out_used_rs,
    output logic                     out_wb,
    output logic [DATAW-1:0]         out_data,
    output logic [PERF_W-1:0]        perf_stalls
);

    typedef struct packed {
        logic [RB-1:0]    rd;
        logic [RB-1:0]    rs1;
        logic [RB-1:0]    rs2;
        logic [RB-1:0]    rs3;
        logic [2:0]       used_rs;
        logic             wb;
        logic             rl;
        logic [DATAW-1:0] data;
    } slot_t;

    slot_t                 slot_q [NUM_WARPS];
    logic [NUM_WARPS-1:0]  slot_valid;
    logic [CNT_W-1:0]      cnt_q [NUM_WARPS][NUM_REGS];
    logic [CNT_W-1:0]      cnt_d [NUM_WARPS][NUM_REGS];
    logic [WW-1:0]         ptr_q;

    logic [NUM_WARPS-1:0]  eligible;
    logic [NUM_WARPS-1:0]  slot_dispatch;
    logic [WW-1:0]         grant;
    logic [WW-1:0]         arb_idx;
    logic                  found;
    logic                  load_en;
    logic                  dispatch;
    logic                  stall;
    logic                  underflow;
    int                    net;

    // Operand hazards are judged on registered counters only (no writeback bypass).
    always_comb begin
        eligible = '0;
        for (int w = 0; w < NUM_WARPS; w++) begin
            eligible[w] = slot_valid[w]
                && !(slot_q[w].used_rs[0] && (cnt_q[w][slot_q[w].rs1] != '0))
                && !(slot_q[w].used_rs[1] && (cnt_q[w][slot_q[w].rs2] != '0))
                && !(slot_q[w].used_rs[2] && (cnt_q[w][slot_q[w].rs3] != '0))
                && !(slot_q[w].wb && ((WAW_MODE == 0) ? (cnt_q[w][slot_q[w].rd] != '0)
                                                      : (cnt_q[w][slot_q[w].rd] == '1)))
                && !(slot_q[w].rl && st_pending[w]);
        end
    end

    // Round-robin pick of the first eligible warp at or after ptr.
    always_comb begin
        grant   = '0;
        arb_idx = '0;
        found   = 1'b0;
        for (int unsigned i = 0; i < NUM_WARPS; i++) begin
            arb_idx = WW'((32'(ptr_q) + i) % NUM_WARPS);
            if (!found && eligible[arb_idx]) begin
                found = 1'b1;
                grant = arb_idx;
            end
        end
    end

    assign load_en  = !out_valid || out_ready;
    assign dispatch = load_en && found;
    assign stall    = (|slot_valid) && !(|eligible);

    always_comb begin
        slot_dispatch = '0;
        for (int w = 0; w < NUM_WARPS; w++) begin
            slot_dispatch[w] = dispatch && (grant == WW'(w));
        end
    end

    assign in_ready = ~slot_valid | slot_dispatch;

    // Net counter update: dispatch increment minus every matching writeback, clamped at 0.
    always_comb begin
        underflow = 1'b0;
        net       = 0;
        for (int w = 0; w < NUM_WARPS; w++) begin
            for (int r = 0; r < NUM_REGS; r++) begin
                cnt_d[w][r] = cnt_q[w][r];
                if (r != 0) begin
                    net = int'(cnt_q[w][r]);
                    if (slot_dispatch[w] && slot_q[w].wb && (slot_q[w].rd == RB'(r))) begin
                        net = net + 1;
                    end
                    for (int p = 0; p < NUM_WB; p++) begin
                        if (wb_valid[p] && (wb_wid[p*WW +: WW] == WW'(w))
                                && (wb_rd[p*RB +: RB] == RB'(r))) begin
                            net = net - 1;
                        end
                    end
                    if (net < 0) begin
                        underflow = 1'b1;
                        net       = 0;
                    end
                    cnt_d[w][r] = CNT_W'(net);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            slot_valid  <= '0;
            ptr_q       <= '0;
            out_valid   <= 1'b0;
            out_wid     <= '0;
            out_rd      <= '0;
            out_rs1     <= '0;
            out_rs2     <= '0;
            out_rs3     <= '0;
            out_used_rs <= '0;
            out_wb      <= 1'b0;
            out_data    <= '0;
            perf_stalls <= '0;
            for (int w = 0; w < NUM_WARPS; w++) begin
                for (int r = 0; r < NUM_REGS; r++) begin
                    cnt_q[w][r] <= '0;
                end
            end
        end else begin
            for (int w = 0; w < NUM_WARPS; w++) begin
                for (int r = 0; r < NUM_REGS; r++) begin
                    cnt_q[w][r] <= cnt_d[w][r];
                end
                if (in_valid[w] && in_ready[w]) begin
                    slot_valid[w] <= 1'b1;
                end else if (slot_dispatch[w]) begin
                    slot_valid[w] <= 1'b0;
                end
            end
            if (load_en) begin
                out_valid <= dispatch;
                if (dispatch) begin
                    out_wid     <= grant;
                    out_rd      <= slot_q[grant].rd;
                    out_rs1     <= slot_q[grant].rs1;
                    out_rs2     <= slot_q[grant].rs2;
                    out_rs3     <= slot_q[grant].rs3;
                    out_used_rs <= slot_q[grant].used_rs;
                    out_wb      <= slot_q[grant].wb;
                    out_data    <= slot_q[grant].data;
                end
            end
            if (dispatch) begin
                ptr_q <= (32'(grant) == NUM_WARPS - 1) ? '0 : grant + 1'b1;
            end
            if (stall && (perf_stalls != '1)) begin
                perf_stalls <= perf_stalls + 1'b1;
            end
        end
    end

    // Slot payload needs no reset; validity is tracked separately.
    always_ff @(posedge clk) begin
        for (int w = 0; w < NUM_WARPS; w++) begin
            if (in_valid[w] && in_ready[w]) begin
                slot_q[w] <= '{rd:      in_rd[w*RB +: RB],
                               rs1:     in_rs1[w*RB +: RB],
                               rs2:     in_rs2[w*RB +: RB],
                               rs3:     in_rs3[w*RB +: RB],
                               used_rs: in_used_rs[w*3 +: 3],
                               wb:      in_wb[w] && (in_rd[w*RB +: RB] != '0),
                               rl:      in_rl[w],
                               data:    in_data[w*DATAW +: DATAW]};
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            assert (!underflow) else $error("scoreboard_mwb: pending-write counter underflow");
        end
    end

endmodule

// File: doc/scoreboard_mwb.md
Name: scoreboard_mwb

Overview:
- Parametrised per-warp register scoreboard with issue arbitration, placed between the instruction buffers and operand collection.
- Generalises the single-writeback, one-bit-per-register design in four ways:
  - NUM_WB parallel writeback ports.
  - Per-register pending-write counters, so a warp can have several outstanding writes to one rd.
  - Selectable WAW policy.
  - Release-fence stall driven by per-warp pending-store status.
- One staging slot per warp feeds a round-robin arbiter with a registered output.

Parameters:
- NUM_WARPS, 4, warps served; one staging slot each.
- NUM_REGS, 64, tracked registers per warp (int+fp); RB = clog2(NUM_REGS).
- NUM_WB, 2, writeback ports.
- CNT_W, 2, width of each pending counter; max outstanding writes per register = 2^CNT_W-1.
- WAW_MODE, 0, 0 = stall while rd counter != 0; 1 = stall only while rd counter is saturated.
- DATAW, 64, opaque payload width.
- PERF_W, 32, stall counter width.
- WW = max(1, clog2(NUM_WARPS)).

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- in_valid  in  NUM_WARPS  per-warp instruction valid
- in_ready  out  NUM_WARPS  per-warp accept
- in_rd/in_rs1/in_rs2/in_rs3  in  NUM_WARPS*RB each  register indices
- in_used_rs  in  NUM_WARPS*3  source-used flags, bit0 = rs1
- in_wb  in  NUM_WARPS  instruction writes rd
- in_rl  in  NUM_WARPS  release semantics
- in_data  in  NUM_WARPS*DATAW  payload
- st_pending  in  NUM_WARPS  warp has outstanding stores
- wb_valid  in  NUM_WB  writeback end-of-packet strobe
- wb_wid  in  NUM_WB*WW  writeback warp
- wb_rd  in  NUM_WB*RB  writeback register
- out_valid  out  1  issued instruction valid
- out_ready  in  1  downstream accept
- out_wid  out  WW  issuing warp
- out_rd/out_rs1/out_rs2/out_rs3  out  RB each
- out_used_rs  out  3
- out_wb  out  1
- out_data  out  DATAW
- perf_stalls  out  PERF_W  stall-cycle counter

Behaviour:

Reset and handshakes:
- Reset: all slots empty, all counters 0, out_valid=0, RR pointer=0, perf_stalls=0; all out_* data fields 0. Reset mid-operation discards slot and output contents with no writeback effect.
- Input: in_ready[w] = !slot_valid[w] || slot_dispatch[w]. Capture happens on in_valid&in_ready; the slot is valid the next cycle.
- Output register: loads when (!out_valid || out_ready). Output holds stable while out_valid&&!out_ready. out_valid deasserts after a fire unless a new dispatch loads.
- Minimum latency: input accepted at t gives out_valid at t+2. Full throughput is 1 instruction/cycle across warps.

Eligibility and dispatch:
- Register 0 is never busy and is never reserved.
- Source busy: used && cnt[w][rs] != 0.
- Rd busy (only when in_wb): WAW_MODE=0 → cnt != 0; WAW_MODE=1 → cnt == 2^CNT_W-1.
- Slot eligible = slot_valid && no busy operand && !(rl && st_pending[w]).
- Eligibility uses registered counters only; there is no same-cycle writeback bypass. A writeback at t frees the register for an eligibility check at t+1.
- Arbiter: round-robin. When output load is enabled, it grants the first eligible warp at or after ptr. ptr becomes grant+1 mod NUM_WARPS on dispatch; otherwise ptr holds.
- Dispatch: slot moves to the output register, and if wb && rd != 0, cnt[w][rd] increments.

Counters:
- Each wb port with wb_valid decrements cnt[wb_wid][wb_rd].
- Multiple ports hitting the same register in the same cycle decrement by the hit count.
- A dispatch increment and writeback decrement(s) on the same register in the same cycle are summed (net change).
- Underflow: clamp at 0 and fire a simulation assertion.
- Overflow is unreachable by construction (saturated rd blocks dispatch).
- Writeback to register 0 is ignored.

Performance counter:
- perf_stalls increments when any slot is valid and no slot is eligible; it saturates at all-ones.

Test Plan:
- Back-to-back independent instructions, warps 0-3, out_ready=1 → out_wid sequence 0,1,2,3; first out_valid 2 cycles after first input; one instruction per cycle thereafter.
- Warp 0 issues wb rd=5, then rs1=5 → second instruction held, perf_stalls increments each cycle. wb_valid[1], wid=0, rd=5 at cycle t → dispatch visible on out at t+2.
- WAW_MODE=1, CNT_W=2: four wb writes to rd=7 with no writeback → first three issue, fourth stalls until one writeback; counter returns to 0 after three writebacks.
- Both wb ports same cycle target warp 1 rd=3 with cnt=2, while warp 1 dispatches a wb to rd=3 → cnt becomes 1.
- in_rl=1 with st_pending[2]=1 → warp 2 held while others issue; deassert st_pending → warp 2 issues 1 cycle later.
- out_ready=0 for 5 cycles with outputs pending → output stable, in_ready drops once slots fill. Assert reset mid-stall → out_valid=0, counters cleared, and a previously busy register is free immediately after reset.
